// File: rtl/sorteador_papeis.sv
// Role-drawing engine: captures the match seed, builds the role table and shuffles it
// with an LFSR-driven Fisher-Yates pass; roles are read back through a combinational port.
//
// state   | meaning
// --------+-----------------------------------------------------------
// OCIOSO  | idle after reset/clear, seed load or start accepted
// CARREGA | fill table with the ordered roles, i = N_JOGADORES-1
// SORTEIA | draw candidate j from LFSR, reject while j > i
// TROCA   | swap table[i] and table[j], decrement i
// PRONTO  | table valid and held, seed load or redraw accepted
module sorteador_papeis #(
    parameter int N_JOGADORES = 8,
    parameter int N_LOBOS     = 2,
    localparam int W          = $clog2(N_JOGADORES)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          zera,
    input  logic          e_seed_reg,
    input  logic [15:0]   seed_in,
    input  logic          iniciar,
    input  logic [W-1:0]  jogador_sel,
    output logic [1:0]    papel_sel,
    output logic          ocupado,
    output logic          pronto,
    output logic [2:0]    db_estado
);

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        CARREGA = 3'd1,
        SORTEIA = 3'd2,
        TROCA   = 3'd3,
        PRONTO  = 3'd4
    } estado_t;

    localparam logic [15:0]  SEMENTE_PADRAO = 16'hACE1;
    localparam logic [15:0]  POLINOMIO      = 16'hB400;
    localparam logic [1:0]   PAPEL_ALDEAO   = 2'd0;
    localparam logic [1:0]   PAPEL_LOBO     = 2'd1;
    localparam logic [1:0]   PAPEL_VIDENTE  = 2'd2;
    localparam logic [1:0]   PAPEL_MEDICO   = 2'd3;
    localparam logic [W-1:0] I_INICIAL      = W'(N_JOGADORES - 1);
    localparam logic [W-1:0] I_ULTIMO       = W'(1);
    localparam logic [W:0]   N_IDX          = (W+1)'(N_JOGADORES);

    estado_t       estado;
    estado_t       prox_estado;
    logic [15:0]   lfsr;
    logic [15:0]   lfsr_passo;
    logic [W-1:0]  idx_i;
    logic [W-1:0]  idx_j;
    logic [W-1:0]  candidato;
    logic [1:0]    tabela [N_JOGADORES];
    logic [1:0]    papel_i;
    logic [1:0]    papel_j;
    logic          carrega_seed;
    logic          carrega_tab;
    logic          passo_lfsr;
    logic          aceita;
    logic          troca;

    assign candidato  = lfsr[W-1:0];
    assign lfsr_passo = (lfsr >> 1) ^ (lfsr[0] ? POLINOMIO : 16'h0000);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= OCIOSO;
        end else begin
            estado <= prox_estado;
        end
    end

    always_comb begin
        prox_estado  = estado;
        ocupado      = 1'b0;
        pronto       = 1'b0;
        carrega_seed = 1'b0;
        carrega_tab  = 1'b0;
        passo_lfsr   = 1'b0;
        aceita       = 1'b0;
        troca        = 1'b0;
        case (estado)
            OCIOSO, PRONTO: begin
                pronto = (estado == PRONTO);
                // a seed load wins over a simultaneous start request
                if (e_seed_reg) begin
                    carrega_seed = 1'b1;
                end else if (iniciar) begin
                    prox_estado = CARREGA;
                end
            end
            CARREGA: begin
                ocupado     = 1'b1;
                carrega_tab = 1'b1;
                prox_estado = SORTEIA;
            end
            SORTEIA: begin
                ocupado    = 1'b1;
                passo_lfsr = 1'b1;
                if (candidato <= idx_i) begin
                    aceita      = 1'b1;
                    prox_estado = TROCA;
                end
            end
            TROCA: begin
                ocupado     = 1'b1;
                troca       = 1'b1;
                prox_estado = (idx_i == I_ULTIMO) ? PRONTO : SORTEIA;
            end
            default: begin
                prox_estado = OCIOSO;
            end
        endcase
        if (zera) begin
            prox_estado = OCIOSO;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr  <= SEMENTE_PADRAO;
            idx_i <= '0;
            idx_j <= '0;
        end else if (zera) begin
            lfsr  <= SEMENTE_PADRAO;
            idx_i <= '0;
            idx_j <= '0;
        end else begin
            // an all-zero seed would lock the LFSR, so it is replaced
            if (carrega_seed) begin
                lfsr <= (seed_in == 16'h0000) ? SEMENTE_PADRAO : seed_in;
            end else if (passo_lfsr) begin
                lfsr <= lfsr_passo;
            end
            if (carrega_tab) begin
                idx_i <= I_INICIAL;
            end else if (troca) begin
                idx_i <= idx_i - W'(1);
            end
            if (aceita) begin
                idx_j <= candidato;
            end
        end
    end

    assign papel_i = tabela[idx_i];
    assign papel_j = tabela[idx_j];

    for (genvar k = 0; k < N_JOGADORES; k++) begin : g_tabela
        localparam logic [W-1:0] K_IDX = W'(k);
        localparam logic [1:0]   PAPEL_INICIAL =
            (k < N_LOBOS)       ? PAPEL_LOBO    :
            (k == N_LOBOS)      ? PAPEL_VIDENTE :
            (k == N_LOBOS + 1)  ? PAPEL_MEDICO  : PAPEL_ALDEAO;

        logic [1:0] papel;

        // when i == j the first branch rewrites the entry with its own value
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                papel <= PAPEL_ALDEAO;
            end else if (zera) begin
                papel <= PAPEL_ALDEAO;
            end else if (carrega_tab) begin
                papel <= PAPEL_INICIAL;
            end else if (troca && (idx_i == K_IDX)) begin
                papel <= papel_j;
            end else if (troca && (idx_j == K_IDX)) begin
                papel <= papel_i;
            end
        end

        assign tabela[k] = papel;
    end

    assign papel_sel = ({1'b0, jogador_sel} < N_IDX) ? tabela[jogador_sel] : PAPEL_ALDEAO;
    assign db_estado = estado;

endmodule

// File: tb/tb_sorteador_papeis.sv
// Directed bench for sorteador_papeis: an 8-player and a 6-player instance share
// the same inputs; draws are checked against hand values and a small shuffle model.
module tb_sorteador_papeis;

    logic        clock = 1'b0;
    logic        reset;
    logic        zera;
    logic        e_seed_reg;
    logic        iniciar;
    logic [15:0] seed_in;
    logic [2:0]  jogador_sel;

    logic [1:0]  papel8;
    logic        ocupado8;
    logic        pronto8;
    logic [2:0]  estado8;
    logic [1:0]  papel6;
    logic        ocupado6;
    logic        pronto6;
    logic [2:0]  estado6;

    int n_chk = 0;
    int n_err = 0;

    always #20 clock = ~clock;

    sorteador_papeis #(.N_JOGADORES(8), .N_LOBOS(2)) dut8 (
        .clock(clock), .reset(reset), .zera(zera), .e_seed_reg(e_seed_reg),
        .seed_in(seed_in), .iniciar(iniciar), .jogador_sel(jogador_sel),
        .papel_sel(papel8), .ocupado(ocupado8), .pronto(pronto8), .db_estado(estado8)
    );

    sorteador_papeis #(.N_JOGADORES(6), .N_LOBOS(2)) dut6 (
        .clock(clock), .reset(reset), .zera(zera), .e_seed_reg(e_seed_reg),
        .seed_in(seed_in), .iniciar(iniciar), .jogador_sel(jogador_sel),
        .papel_sel(papel6), .ocupado(ocupado6), .pronto(pronto6), .db_estado(estado6)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ler8(output logic [15:0] t);
        for (int k = 0; k < 8; k++) begin
            jogador_sel = 3'(k);
            #1;
            t[2*k +: 2] = papel8;
        end
    endtask

    task automatic ler6(output logic [11:0] t);
        for (int k = 0; k < 6; k++) begin
            jogador_sel = 3'(k);
            #1;
            t[2*k +: 2] = papel6;
        end
    endtask

    // packs {werewolves, seers, doctors, villagers}, 8 bits each
    function automatic logic [31:0] contagem(input logic [31:0] t, input int n);
        int c [4];
        for (int k = 0; k < 4; k++) c[k] = 0;
        for (int k = 0; k < n; k++) c[int'(t[2*k +: 2])]++;
        return {8'(c[1]), 8'(c[2]), 8'(c[3]), 8'(c[0])};
    endfunction

    // Fisher-Yates reference with two werewolves; the 3-bit candidate mask holds for 5..8 players
    function automatic void modelo(input int n, input logic [15:0] semente, output int lat,
                                   output logic [31:0] tab, output logic [15:0] s_fim);
        logic [15:0] s;
        logic [1:0]  t [16];
        logic [1:0]  tmp;
        int          c;
        s = (semente == 16'h0000) ? 16'hACE1 : semente;
        for (int k = 0; k < 16; k++) t[k] = 2'd0;
        t[0] = 2'd1; t[1] = 2'd1; t[2] = 2'd2; t[3] = 2'd3;
        lat = 1;
        for (int i = n - 1; i >= 1; i--) begin
            c = n;
            while (c > i) begin
                c = int'(s[2:0]);
                s = {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
                lat++;
            end
            tmp  = t[i];
            t[i] = t[c];
            t[c] = tmp;
            lat++;
        end
        tab = '0;
        for (int k = 0; k < 16; k++) tab[2*k +: 2] = t[k];
        s_fim = s;
    endfunction

    initial begin
        int          cyc;
        int          lat_m;
        logic [31:0] tab_m;
        logic [15:0] lfsr_m;
        logic [15:0] t8;
        logic [11:0] t6;
        logic [15:0] semente;
        logic [15:0] efetiva;
        logic [1:0]  exp1 [8];

        exp1 = '{2'd0, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1};
        reset = 1'b1; zera = 1'b0; e_seed_reg = 1'b0; iniciar = 1'b0;
        seed_in = 16'h0000; jogador_sel = 3'd0;
        repeat (2) tick();
        reset = 1'b0;
        tick();

        chk("rst_estado", 32'(estado8), 32'd0);
        chk("rst_pronto", 32'(pronto8), 32'd0);
        chk("rst_ocupado", 32'(ocupado8), 32'd0);
        chk("rst_lfsr", 32'(dut8.lfsr), 32'hACE1);
        ler8(t8);
        chk("rst_tabela", 32'(t8), 32'd0);
        chk("rst_estado6", 32'(estado6), 32'd0);

        // seed 0x0001, hand-traced draw
        seed_in = 16'h0001; e_seed_reg = 1'b1;
        tick();
        e_seed_reg = 1'b0;
        chk("seed1_lfsr", 32'(dut8.lfsr), 32'h0001);
        chk("seed1_fica_ocioso", 32'(estado8), 32'd0);
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        chk("seed1_carrega", 32'(estado8), 32'd1);
        chk("seed1_ocupado", 32'(ocupado8), 32'd1);
        cyc = 0;
        while (!pronto8 && cyc < 100) begin tick(); cyc++; end
        chk("seed1_latencia", 32'(cyc), 32'd15);
        chk("seed1_estado", 32'(estado8), 32'd4);
        chk("seed1_ocupado_fim", 32'(ocupado8), 32'd0);
        ler8(t8);
        for (int k = 0; k < 8; k++) chk("seed1_papel", 32'(t8[2*k +: 2]), 32'(exp1[k]));
        chk("seed1_lfsr_fim", 32'(dut8.lfsr), 32'h02D0);

        // seed load and start in the same cycle: load wins, no draw
        seed_in = 16'h1234; e_seed_reg = 1'b1; iniciar = 1'b1;
        tick();
        e_seed_reg = 1'b0; iniciar = 1'b0;
        chk("simult_estado", 32'(estado8), 32'd4);
        chk("simult_lfsr", 32'(dut8.lfsr), 32'h1234);

        // zero seed, with seed/start pulses during the draw
        seed_in = 16'h0000; e_seed_reg = 1'b1;
        tick();
        e_seed_reg = 1'b0;
        chk("seed0_lfsr", 32'(dut8.lfsr), 32'hACE1);
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        cyc = 0;
        seed_in = 16'h5555; e_seed_reg = 1'b1;
        tick();
        e_seed_reg = 1'b0;
        cyc++;
        chk("meio_seed_ignorada", 32'(dut8.lfsr), 32'hACE1);
        chk("meio_sorteia", 32'(estado8), 32'd2);
        tick(); cyc++;
        iniciar = 1'b1;
        tick(); cyc++;
        iniciar = 1'b0;
        while (!pronto8 && cyc < 100) begin tick(); cyc++; end
        modelo(8, 16'h0000, lat_m, tab_m, lfsr_m);
        chk("seed0_latencia", 32'(cyc), 32'(lat_m));
        ler8(t8);
        chk("seed0_tabela", 32'(t8), 32'(tab_m[15:0]));
        chk("seed0_contagem", contagem(32'(t8), 8), {8'd2, 8'd1, 8'd1, 8'd4});
        chk("seed0_lfsr_fim", 32'(dut8.lfsr), 32'(lfsr_m));

        // clear while swapping
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        cyc = 0;
        while (estado8 != 3'd3 && cyc < 50) begin tick(); cyc++; end
        chk("zera_chega_troca", 32'(estado8), 32'd3);
        zera = 1'b1;
        tick();
        zera = 1'b0;
        chk("zera_estado", 32'(estado8), 32'd0);
        chk("zera_pronto", 32'(pronto8), 32'd0);
        chk("zera_ocupado", 32'(ocupado8), 32'd0);
        chk("zera_lfsr", 32'(dut8.lfsr), 32'hACE1);
        ler8(t8);
        chk("zera_tabela", 32'(t8), 32'd0);

        seed_in = 16'h7777; zera = 1'b1; e_seed_reg = 1'b1; iniciar = 1'b1;
        tick();
        zera = 1'b0; e_seed_reg = 1'b0; iniciar = 1'b0;
        chk("zera_prio_estado", 32'(estado8), 32'd0);
        chk("zera_prio_lfsr", 32'(dut8.lfsr), 32'hACE1);

        // asynchronous reset in the middle of a draw
        e_seed_reg = 1'b1;
        tick();
        e_seed_reg = 1'b0;
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        repeat (3) tick();
        #5;
        reset = 1'b1;
        #1;
        chk("rst_meio_estado", 32'(estado8), 32'd0);
        chk("rst_meio_ocupado", 32'(ocupado8), 32'd0);
        chk("rst_meio_lfsr", 32'(dut8.lfsr), 32'hACE1);
        chk("rst_meio_estado6", 32'(estado6), 32'd0);
        ler8(t8);
        chk("rst_meio_tabela", 32'(t8), 32'd0);
        reset = 1'b0;
        tick();

        // six players, fifty seeds
        for (int s = 0; s < 50; s++) begin
            semente = (s == 0) ? 16'h0000 : 16'($urandom_range(1, 65535));
            efetiva = (semente == 16'h0000) ? 16'hACE1 : semente;
            seed_in = semente; e_seed_reg = 1'b1;
            tick();
            e_seed_reg = 1'b0;
            iniciar = 1'b1;
            tick();
            iniciar = 1'b0;
            cyc = 0;
            while (!pronto6 && cyc < 200) begin tick(); cyc++; end
            modelo(6, semente, lat_m, tab_m, lfsr_m);
            ler6(t6);
            chk("n6_contagem", contagem(32'(t6), 6), {8'd2, 8'd1, 8'd1, 8'd2});
            chk("n6_lat_min", 32'(cyc >= 11), 32'd1);
            if (efetiva[2:0] > 3'd5) chk("n6_lat_rejeicao", 32'(cyc >= 12), 32'd1);
            chk("n6_latencia", 32'(cyc), 32'(lat_m));
            chk("n6_tabela", 32'(t6), 32'(tab_m[11:0]));
            chk("n6_lfsr_fim", 32'(dut6.lfsr), 32'(lfsr_m));
        end

        jogador_sel = 3'd6;
        #1;
        chk("n6_fora_6", 32'(papel6), 32'd0);
        jogador_sel = 3'd7;
        #1;
        chk("n6_fora_7", 32'(papel6), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sorteador_papeis.md
# sorteador_papeis

Role-drawing engine for the game datapath. Captures the match seed when the control unit pulses `e_seed_reg`, then, on `iniciar`, builds a role table (werewolves, seer, doctor, villagers) and shuffles it with an LFSR-driven Fisher–Yates pass. It sits directly downstream of the game control unit. The night/day phase logic reads each player's role through a combinational read port.

## Interface
- `N_JOGADORES`, default 8: number of players. Range 4..16.
- `N_LOBOS`, default 2: number of werewolves. Range 1..N_JOGADORES-2.
- `W`, derived as clog2(N_JOGADORES): player index width.
- `clock`  in  1  system clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `zera`  in  1  synchronous clear, driven by the control unit's `rst_global`.
- `e_seed_reg`  in  1  seed capture enable, a one-cycle pulse.
- `seed_in`  in  16  seed value from the free-running counter.
- `iniciar`  in  1  start-draw pulse.
- `jogador_sel`  in  W  player index for the read port.
- `papel_sel`  out  2  role of `jogador_sel`. Encoding: 0 villager, 1 werewolf, 2 seer, 3 doctor.
- `ocupado`  out  1  high during CARREGA, SORTEIA and TROCA.
- `pronto`  out  1  high while in PRONTO.
- `db_estado`  out  3  current state code.

## Operation
- States and codes: OCIOSO=0, CARREGA=1, SORTEIA=2, TROCA=3, PRONTO=4. Any unused code returns to OCIOSO.
- Seed register `lfsr` (16 bit):
  - Loaded on `e_seed_reg` only in OCIOSO or PRONTO. Ignored in any other state.
  - If `seed_in`==0, loads 16'hACE1 instead.
- LFSR step is Galois right-shift: `lfsr <= (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0)`.
- OCIOSO/PRONTO + `iniciar` (and no `e_seed_reg` that cycle): go to CARREGA. If `e_seed_reg` and `iniciar` arrive together, the seed is loaded and `iniciar` is ignored.
- CARREGA (1 cycle):
  - Fills the table: entries 0..N_LOBOS-1 = werewolf, entry N_LOBOS = seer, entry N_LOBOS+1 = doctor, the rest = villager.
  - Sets i = N_JOGADORES-1, then goes to SORTEIA.
- SORTEIA (one LFSR step per cycle):
  - Candidate c = `lfsr[W-1:0]`, taken before the step.
  - If c<=i: latch j=c and go to TROCA.
  - Else: reject and stay in SORTEIA.
  - The LFSR steps in both cases.
- TROCA (1 cycle):
  - Swaps table[i] and table[j]. i==j is a no-op swap.
  - Decrements i. If the old i was 1, go to PRONTO; else back to SORTEIA.
- PRONTO: holds the table. A new `iniciar` redraws, continuing from the current LFSR state.
- `iniciar` while `ocupado` is ignored.
- `zera`:
  - Overrides everything, in any state, next edge.
  - State goes to OCIOSO, the table clears to all villagers, `lfsr` goes to 16'hACE1.
- Read port: `papel_sel` = table[`jogador_sel`], combinational. Any index >= N_JOGADORES reads 0.
- Invariant: after every draw, the table contains exactly N_LOBOS werewolves, 1 seer, 1 doctor, and the rest villagers.

## Timing
- Reset values:
  - state OCIOSO, `lfsr`=16'hACE1, table all 0.
  - `pronto`=0, `ocupado`=0, `db_estado`=0, `papel_sel`=0.
- All outputs except `papel_sel` are Moore, decoded from state.
- `ocupado` rises the cycle after the accepted `iniciar`.
- Latency with no rejections: 1 (CARREGA) + 2·(N_JOGADORES-1) cycles from entering CARREGA to PRONTO. For N=8 that is 15 cycles.
- Each rejection adds 1 cycle. N power of two gives zero rejections at i=N-1.
- Seed load is visible on `lfsr` the edge after `e_seed_reg`.
- `zera` has priority over `e_seed_reg` and `iniciar` in the same cycle.
- Asynchronous `reset` mid-draw: immediate return to reset values. No partial table is retained.

## Test plan
- Reset, then idle: `pronto`=0, `ocupado`=0, `db_estado`=0, every `papel_sel`=0.
- `seed_in`=16'h0001, pulse `e_seed_reg`, then `iniciar` (N=8, LOBOS=2):
  - `pronto` exactly 15 cycles after CARREGA entry.
  - Table for players 0..7 = 0,2,3,0,0,0,1,1.
  - Final `lfsr` = 16'h02D0.
- `seed_in`=0, load, then draw: `lfsr` loads 16'hACE1. Final role counts are 2 werewolves, 1 seer, 1 doctor, 4 villagers.
- `iniciar` pulsed mid-draw, and `e_seed_reg` pulsed mid-draw: the draw is unaffected, and the seed is unchanged in the cycle after the pulse.
- `zera` asserted during TROCA: the next cycle is OCIOSO, the table is all 0, `lfsr`=16'hACE1, `pronto`=0.
- N=6 parameterization, 50 random seeds: every draw yields the role-count invariant. Latency is ≥ 11 cycles, and ≥ 12 whenever the candidate at i=5 was rejected.
